pool_window_feeder: RTL
=======================

Name: pool_window_feeder

Overview:
- Upstream neighbour of the 2x2 average-pooling stage.
- Accepts one feature-map plane as a row-major stream of 16-bit signed pixels with a valid/ready handshake.
- Buffers one image row and emits non-overlapping 2x2 windows (stride 2) plus a one-cycle start strobe that drives the pooler's start input.
- For odd dimensions, trailing rows and columns are consumed and discarded, giving floor(W/2) x floor(H/2) windows per frame.

Parameters:
- W, 28, feature-map width in pixels (>=2).
- H, 28, feature-map height in pixels (>=2).
- DATA_W, 16, pixel width; signed, passed through unmodified.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- pix_valid  input  1  pix_data is valid.
- pix_ready  output  1  block accepts a pixel this cycle.
- pix_data  input  DATA_W  stream pixel, row-major, row 0 first.
- win_valid  output  1  window registers hold a valid 2x2 window.
- win_ready  input  1  downstream consumes the window.
- win_00, win_01, win_10, win_11  output  DATA_W each  window pixels [row][col] relative to the window's top-left.
- win_row  output  $clog2(H/2)+1  output row index of the window (r/2).
- win_col  output  $clog2(W/2)+1  output column index of the window (c/2).
- pool_start  output  1  pulse, equal to win_valid & win_ready.
- frame_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (asynchronous, rst=1): state=ACCEPT, row=col=0, win_valid=0, frame_done=0, window and index outputs=0, line buffer contents don't-care. pix_ready follows state, so it is 1 once rst deasserts.
- Storage:
  - Line buffer of floor(W/2)*2 entries. It captures every pixel of even rows whose col < 2*floor(W/2).
  - One "left" register holds the previous pixel of the current odd row.
- Counters:
  - A pixel is accepted on pix_valid & pix_ready.
  - col increments per accepted pixel and wraps to 0 after W-1; row then increments and wraps to 0 after H-1.
- Window formation: an accepted pixel at (r,c) completes a window when all of the following hold:
  - r is odd, c is odd;
  - r < 2*floor(H/2);
  - c < 2*floor(W/2).
- Window register loads on completion:
  - win_00=linebuf[c-1], win_01=linebuf[c], win_10=left, win_11=pix_data.
  - win_row=r>>1, win_col=c>>1.
- FSM states ACCEPT, EMIT, DONE:
  - ACCEPT: pix_ready=1. A window-completing pixel → EMIT, with win_valid=1 the next cycle (latency 1 clock from acceptance). Accepting the frame's final pixel (H-1,W-1) without completing a window → DONE.
  - EMIT: pix_ready=0, win_valid=1, outputs held stable. On win_ready: win_valid=0, pool_start=1 that cycle. Next state is DONE if that window came from pixel (H-1,W-1), else ACCEPT. No combinational path from win_ready to pix_ready.
  - DONE: frame_done=1 for exactly one cycle, pix_ready=0, → ACCEPT. Counters are already wrapped to (0,0), and the next frame begins without reset.
- Boundary and corner cases:
  - pix_valid high while pix_ready=0: the pixel is not consumed; the upstream must hold it.
  - win_ready held high while in ACCEPT: ignored, no pool_start.
  - Odd W: the column W-1 pixel is accepted and discarded (not stored, no window). Odd H: all pixels of row H-1 are accepted and discarded. In both cases frame_done still fires after (H-1,W-1).
  - rst asserted mid-frame or mid-EMIT: the window is dropped and counters return to 0; the next accepted pixel is treated as (0,0).
- Throughput: one pixel per cycle except one stall cycle per window (EMIT with win_ready=1) and one per frame (DONE).

Test Plan:
- W=H=4, pixels 1..16 streamed continuously, win_ready=1:
  - windows (0,0)={1,2,5,6}, (0,1)={3,4,7,8}, (1,0)={9,10,13,14}, (1,1)={11,12,15,16};
  - 4 pool_start pulses; frame_done once, one cycle after the last handshake.
- Same stream, win_ready held low 5 cycles on first window: win_valid and data are stable throughout, pix_ready=0, no pixel lost, and the remaining windows match the previous case.
- W=H=5, pixels 1..25: 4 windows {1,2,6,7}, {3,4,8,9}, {11,12,16,17}, {13,14,18,19}. Column 4 and row 4 are discarded; frame_done follows acceptance of pixel 25.
- Signed data, W=H=2, pixels -32768, 32767, -1, 0: window is passed through bit-exact, with win_row=win_col=0.
- Assert rst after 6 pixels of a 4x4 frame, then stream 1..16: outputs match the first scenario, with no stale window.
- Two back-to-back 4x4 frames with random pix_valid gaps: 8 windows and 2 frame_done pulses, and indices restart at (0,0).

Source files
------------

// File: rtl/pool_window_feeder.sv
// pool_window_feeder: turns a row-major pixel stream into non-overlapping 2x2 windows for the average pooler.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pix_valid/ready     input pixel handshake, pix_data is the signed pixel
//   win_valid/ready     window handshake, win_00..win_11 are [row][col] of the window
//   win_row, win_col    window index (r/2, c/2)
//   pool_start          pulse when a window is handed over (win_valid & win_ready)
//   frame_done          one-cycle pulse after the last pixel/window of a frame
module pool_window_feeder #(
   parameter int W      = 28,
   parameter int H      = 28,
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   input  logic [DATA_W-1:0]        pix_data,
   output logic                     win_valid,
   input  logic                     win_ready,
   output logic [DATA_W-1:0]        win_00,
   output logic [DATA_W-1:0]        win_01,
   output logic [DATA_W-1:0]        win_10,
   output logic [DATA_W-1:0]        win_11,
   output logic [$clog2(H/2):0]     win_row,
   output logic [$clog2(W/2):0]     win_col,
   output logic                     pool_start,
   output logic                     frame_done
);
   localparam int WW = W / 2;
   localparam int HH = H / 2;
   localparam int CW = $clog2(W + 1);
   localparam int RW = $clog2(H + 1);
   localparam int AW = $clog2(2 * WW);
   localparam int RO = $clog2(H / 2) + 1;
   localparam int CO = $clog2(W / 2) + 1;
   localparam logic [CW-1:0] C_LAST = CW'(W - 1);
   localparam logic [CW-1:0] C_LIM  = CW'(2 * WW);
   localparam logic [RW-1:0] R_LAST = RW'(H - 1);
   localparam logic [RW-1:0] R_LIM  = RW'(2 * HH);

   typedef enum logic [1:0] {ACCEPT, EMIT, DONE} state_t;

   state_t            state, next;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [DATA_W-1:0] lb [2*WW];
   logic [DATA_W-1:0] left;
   logic              last_win;
   logic              acc, last_pix, complete;
   logic [AW-1:0]     ca;

   assign pix_ready  = state == ACCEPT;
   assign win_valid  = state == EMIT;
   assign pool_start = win_valid & win_ready;
   assign frame_done = state == DONE;
   assign acc        = pix_valid & pix_ready;
   assign last_pix   = row == R_LAST && col == C_LAST;
   // trailing odd row/column never completes a window and is only counted
   assign complete   = acc & row[0] & col[0] & (row < R_LIM) & (col < C_LIM);
   assign ca         = col[AW-1:0];

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ACCEPT;
      else     state <= next;

   always_comb begin
      next = state;
      case (state)
         ACCEPT:  next = complete ? EMIT : (acc && last_pix) ? DONE : ACCEPT;
         EMIT:    next = !win_ready ? EMIT : last_win ? DONE : ACCEPT;
         default: next = ACCEPT;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         col      <= '0;
         row      <= '0;
         last_win <= 1'b0;
         win_00   <= '0;
         win_01   <= '0;
         win_10   <= '0;
         win_11   <= '0;
         win_row  <= '0;
         win_col  <= '0;
      end else begin
         if (acc) begin
            col <= col == C_LAST ? '0 : col + 1'b1;
            if (col == C_LAST) row <= row == R_LAST ? '0 : row + 1'b1;
         end
         if (complete) begin
            // ca is odd here, so clearing bit 0 addresses column c-1
            win_00   <= lb[ca & ~AW'(1)];
            win_01   <= lb[ca];
            win_10   <= left;
            win_11   <= pix_data;
            win_row  <= RO'(row >> 1);
            win_col  <= CO'(col >> 1);
            last_win <= last_pix;
         end
      end

   // line buffer and left pixel are storage only; their reset value is irrelevant
   always_ff @(posedge clk) begin
      if (acc && !row[0] && col < C_LIM) lb[ca] <= pix_data;
      if (acc && row[0]) left <= pix_data;
   end
endmodule
